// File: rtl/led_display_pkg.sv
// Shared encodings and default parameters for the LED bar display.
package led_display_pkg;

    typedef enum logic [1:0] {
        MODE_BAR  = 2'b00,
        MODE_DOT  = 2'b01,
        MODE_PEAK = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        PK_TRACK = 2'd0,
        PK_HOLD  = 2'd1,
        PK_DECAY = 2'd2
    } peak_state_e;

    localparam int DEF_N_LEDS       = 16;
    localparam int DEF_HOLD_CYCLES  = 1000;
    localparam int DEF_DECAY_CYCLES = 100;
    localparam int DEF_BLINK_CYCLES = 500;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_decode.sv
// Combinational level decoder: thermometer (i < level) or one-hot (bit level-1).
module led_decode #(
    parameter int N_LEDS = 16,
    parameter int LVL_W  = $clog2(N_LEDS + 1)
) (
    input  logic [LVL_W-1:0]  i_level,
    input  logic              i_onehot,
    output logic [N_LEDS-1:0] o_pattern
);

    always_comb begin
        o_pattern = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            if (i_onehot) begin
                o_pattern[i] = (int'(i_level) == i + 1);
            end else begin
                o_pattern[i] = (i < int'(i_level));
            end
        end
    end

endmodule

// File: rtl/led_bar_display.sv
// LED bar/dot/peak-marker display with peak hold-and-decay and overflow blink.
module led_bar_display
    import led_display_pkg::*;
#(
    parameter int N_LEDS       = DEF_N_LEDS,
    parameter int LVL_W        = $clog2(N_LEDS + 1),
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int DECAY_CYCLES = DEF_DECAY_CYCLES,
    parameter int BLINK_CYCLES = DEF_BLINK_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LVL_W-1:0]  level_in,
    input  logic              level_valid,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] led_out,
    output logic [LVL_W-1:0]  peak_out,
    output logic              over_out
);

    localparam int HOLD_W  = cnt_width(HOLD_CYCLES);
    localparam int DECAY_W = cnt_width(DECAY_CYCLES);
    localparam int BLINK_W = cnt_width(BLINK_CYCLES);

    localparam logic [LVL_W-1:0]   LVL_MAX    = LVL_W'(N_LEDS);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [LVL_W-1:0]   r_level_q;
    logic               r_over_q;
    logic [LVL_W-1:0]   r_peak;
    peak_state_e        r_state;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [DECAY_W-1:0] r_decay_cnt;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_off;
    logic [N_LEDS-1:0]  r_led;

    mode_e              w_mode;
    logic [LVL_W-1:0]   w_sample;
    logic               w_new_peak;
    logic [N_LEDS-1:0]  w_level_pat;
    logic [N_LEDS-1:0]  w_marker_pat;
    logic [N_LEDS-1:0]  w_pattern;

    assign w_mode     = mode_e'(mode);
    assign w_sample   = (level_in > LVL_MAX) ? LVL_MAX : level_in;
    assign w_new_peak = level_valid && (w_sample > r_peak);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_q <= '0;
            r_over_q  <= 1'b0;
        end else if (level_valid) begin
            r_level_q <= w_sample;
            r_over_q  <= (level_in > LVL_MAX);
        end
    end

    // A fresh higher sample always wins, even over a decay step due this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PK_TRACK;
            r_peak      <= '0;
            r_hold_cnt  <= '0;
            r_decay_cnt <= '0;
        end else if (w_new_peak) begin
            r_state    <= PK_HOLD;
            r_peak     <= w_sample;
            r_hold_cnt <= HOLD_LAST;
        end else begin
            case (r_state)
                PK_TRACK: r_peak <= r_level_q;
                PK_HOLD: begin
                    if (r_hold_cnt == '0) begin
                        r_state     <= PK_DECAY;
                        r_decay_cnt <= DECAY_LAST;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end
                end
                PK_DECAY: begin
                    if (r_peak <= r_level_q) begin
                        r_peak  <= r_level_q;
                        r_state <= PK_TRACK;
                    end else if (r_decay_cnt == '0) begin
                        r_peak      <= r_peak - LVL_W'(1);
                        r_decay_cnt <= DECAY_LAST;
                    end else begin
                        r_decay_cnt <= r_decay_cnt - DECAY_W'(1);
                    end
                end
                default: r_state <= PK_TRACK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (!r_over_q) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_off <= ~r_blink_off;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
    end

    led_decode #(.N_LEDS(N_LEDS), .LVL_W(LVL_W)) u_level_dec (
        .i_level   (r_level_q),
        .i_onehot  (w_mode == MODE_DOT),
        .o_pattern (w_level_pat)
    );

    led_decode #(.N_LEDS(N_LEDS), .LVL_W(LVL_W)) u_marker_dec (
        .i_level   (r_peak),
        .i_onehot  (1'b1),
        .o_pattern (w_marker_pat)
    );

    always_comb begin
        w_pattern = '0;
        case (w_mode)
            MODE_BAR, MODE_DOT: w_pattern = w_level_pat;
            MODE_PEAK:          w_pattern = w_level_pat | w_marker_pat;
            default:            w_pattern = '0;
        endcase
        if (r_over_q && (w_mode != MODE_OFF)) begin
            w_pattern[N_LEDS-1] = ~r_blink_off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= '0;
        end else begin
            r_led <= w_pattern;
        end
    end

    assign led_out  = r_led;
    assign peak_out = r_peak;
    assign over_out = r_over_q;

endmodule

// File: tb/tb_led_bar_display.sv
// Directed bench for led_bar_display: bar sweep, dot, peak hold/decay, overflow blink, reset.
`timescale 1ns/1ps
module tb_led_bar_display;
    import led_display_pkg::*;

    localparam int N  = 16;
    localparam int LW = 5;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b0;
    logic [LW-1:0] level_in    = '0;
    logic          level_valid = 1'b0;
    logic [1:0]    mode        = 2'b00;
    logic [N-1:0]  led_out;
    logic [LW-1:0] peak_out;
    logic          over_out;

    int n_checks = 0;
    int n_fail   = 0;
    int e        = 0;

    led_bar_display #(
        .N_LEDS       (N),
        .LVL_W        (LW),
        .HOLD_CYCLES  (8),
        .DECAY_CYCLES (4),
        .BLINK_CYCLES (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .level_in    (level_in),
        .level_valid (level_valid),
        .mode        (mode),
        .led_out     (led_out),
        .peak_out    (peak_out),
        .over_out    (over_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic tick_to(input int t);
        while (e < t) tick();
    endtask

    task automatic strobe(input int lvl);
        level_in    = LW'(lvl);
        level_valid = 1'b1;
        tick();
        level_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_v;

        // Reset state
        #2;
        check_eq("rst_led",   32'(led_out),     32'h0);
        check_eq("rst_peak",  32'(peak_out),    32'h0);
        check_eq("rst_over",  32'(over_out),    32'h0);
        check_eq("rst_state", 32'(dut.r_state), 32'(PK_TRACK));
        #1 rst_n = 1'b1;
        tick();

        // BAR sweep
        mode = 2'b00;
        for (int l = 0; l <= 16; l++) begin
            strobe(l);
            tick();
            exp_v = (32'd1 << l) - 32'd1;
            check_eq($sformatf("bar_%0d", l), 32'(led_out), exp_v);
            tick();
            tick();
        end

        // DOT
        mode = 2'b01;
        strobe(5);
        tick();
        check_eq("dot_5", 32'(led_out), 32'h0010);
        strobe(0);
        tick();
        check_eq("dot_0", 32'(led_out), 32'h0000);

        // OFF after BAR
        mode = 2'b00;
        strobe(7);
        tick();
        check_eq("bar_7", 32'(led_out), 32'h007F);
        mode = 2'b11;
        tick();
        check_eq("off", 32'(led_out), 32'h0000);

        // PEAK hold and decay back to TRACK
        do_reset();
        mode = 2'b10;
        e = -1;
        strobe(12);
        strobe(3);
        tick();
        check_eq("pk_led_e2", 32'(led_out), 32'h0807);
        check_eq("pk_peak_e2", 32'(peak_out), 32'd12);
        while (e < 12) begin
            tick();
            check_eq($sformatf("pk_hold_e%0d", e), 32'(led_out), 32'h0807);
        end
        tick_to(13);
        check_eq("pk_led_e13", 32'(led_out), 32'h0407);
        check_eq("pk_peak_e13", 32'(peak_out), 32'd11);
        tick_to(17);
        check_eq("pk_led_e17", 32'(led_out), 32'h0207);
        tick_to(41);
        check_eq("pk_led_e41", 32'(led_out), 32'h000F);
        tick_to(44);
        check_eq("pk_state_e44", 32'(dut.r_state), 32'(PK_DECAY));
        check_eq("pk_peak_e44", 32'(peak_out), 32'd3);
        tick_to(45);
        check_eq("pk_state_e45", 32'(dut.r_state), 32'(PK_TRACK));
        check_eq("pk_peak_e45", 32'(peak_out), 32'd3);
        check_eq("pk_led_e45", 32'(led_out), 32'h0007);

        // New sample beats a decay step due on the same edge
        do_reset();
        e = -1;
        strobe(12);
        strobe(3);
        tick_to(31);
        check_eq("sim_peak7", 32'(peak_out), 32'd7);
        check_eq("sim_state_decay", 32'(dut.r_state), 32'(PK_DECAY));
        strobe(10);
        check_eq("sim_peak10", 32'(peak_out), 32'd10);
        check_eq("sim_state_hold", 32'(dut.r_state), 32'(PK_HOLD));
        tick();
        tick();
        check_eq("sim_led_prerst", 32'(led_out), 32'h03FF);

        // Asynchronous reset mid-HOLD
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_led",   32'(led_out),     32'h0);
        check_eq("arst_peak",  32'(peak_out),    32'h0);
        check_eq("arst_over",  32'(over_out),    32'h0);
        check_eq("arst_state", 32'(dut.r_state), 32'(PK_TRACK));
        #1 rst_n = 1'b1;
        tick();
        check_eq("post_rst_peak",  32'(peak_out),    32'h0);
        check_eq("post_rst_state", 32'(dut.r_state), 32'(PK_TRACK));
        check_eq("post_rst_led",   32'(led_out),     32'h0);

        // Overflow blink in BAR
        mode = 2'b00;
        strobe(31);
        check_eq("ovf_over", 32'(over_out), 32'h1);
        for (int j = 1; j <= 9; j++) begin
            tick();
            exp_v = (((j - 1) / 3) % 2 == 1) ? 32'h7FFF : 32'hFFFF;
            check_eq($sformatf("ovf_blink_%0d", j), 32'(led_out), exp_v);
        end
        strobe(4);
        check_eq("ovf_clear", 32'(over_out), 32'h0);
        tick();
        check_eq("ovf_led4", 32'(led_out), 32'h000F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
